// File: rtl/source_buffer.sv
// -----------------------------------------------------------------------------
// source_buffer
//
// Two-write / two-read on-chip buffer that holds source-node feature vectors
// for the GNN accelerator datapath. Each entry is one complete feature vector
// of NUM lanes x WL bits. Upstream loaders fill entries through write ports
// A and B. The compute array pulls two vectors per cycle through read ports
// A and B.
//
// Ports (all synchronous to the rising edge of clock):
//   clock            - single clock
//   reset            - synchronous, active-high; clears q_a/q_b, blocks writes
//   data_a           - port A write data            [WL*NUM]
//   write_address_a  - port A write address         [AW]
//   wren_a           - port A write enable
//   read_address_a   - port A read address          [AW]
//   q_a              - port A read data, registered [WL*NUM]
//   data_b           - port B write data            [WL*NUM]
//   write_address_b  - port B write address         [AW]
//   wren_b           - port B write enable
//   read_address_b   - port B read address          [AW]
//   q_b              - port B read data, registered [WL*NUM]
//
// Behaviour notes:
//   - Read latency is one cycle. A read and a write to the same address on
//     the same edge returns the OLD contents.
//   - When both ports write the same address on the same edge, port A wins.
//   - Reset does not clear the storage array. Entries written before reset
//     keep their contents.
// -----------------------------------------------------------------------------
module source_buffer #(
  parameter int WL    = 32,
  parameter int NUM   = 128,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WL*NUM-1:0]   data_a,
  input  logic [AW-1:0]       write_address_a,
  input  logic                wren_a,
  input  logic [AW-1:0]       read_address_a,
  output logic [WL*NUM-1:0]   q_a,
  input  logic [WL*NUM-1:0]   data_b,
  input  logic [AW-1:0]       write_address_b,
  input  logic                wren_b,
  input  logic [AW-1:0]       read_address_b,
  output logic [WL*NUM-1:0]   q_b
);

  localparam int W = WL * NUM;

  // Storage array. It has no reset, so synthesis can map it onto block RAM.
  logic [W-1:0] mem [DEPTH];

  logic [W-1:0] q_a_reg;
  logic [W-1:0] q_b_reg;

  // Port B yields to port A when both target the same entry on one edge.
  logic b_collides;
  assign b_collides = wren_a && (write_address_a == write_address_b);

  // Write path. Writes issued during a reset cycle are dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wren_a) begin
        mem[write_address_a] <= data_a;
      end
      if (wren_b && !b_collides) begin
        mem[write_address_b] <= data_b;
      end
    end
  end

  // Read path. The non-blocking update of mem above means a same-edge read
  // sees the pre-write contents (read-old-data behaviour).
  always_ff @(posedge clock) begin
    if (reset) begin
      q_a_reg <= '0;
      q_b_reg <= '0;
    end else begin
      q_a_reg <= mem[read_address_a];
      q_b_reg <= mem[read_address_b];
    end
  end

  assign q_a = q_a_reg;
  assign q_b = q_b_reg;

endmodule

// File: tb/tb_source_buffer.sv
// -----------------------------------------------------------------------------
// tb_source_buffer
//
// Directed self-checking bench for source_buffer at default parameters
// (32-bit lanes, 128 lanes, 1024 entries). Each scenario task drives stimulus
// and compares the registered outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_source_buffer;

  localparam int WL    = 32;
  localparam int NUM   = 128;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int W     = WL * NUM;

  logic          clock;
  logic          reset;
  logic [W-1:0]  data_a;
  logic [AW-1:0] write_address_a;
  logic          wren_a;
  logic [AW-1:0] read_address_a;
  logic [W-1:0]  q_a;
  logic [W-1:0]  data_b;
  logic [AW-1:0] write_address_b;
  logic          wren_b;
  logic [AW-1:0] read_address_b;
  logic [W-1:0]  q_b;

  int assertions;
  int failures;

  logic [W-1:0] pattern;
  logic [W-1:0] pattern_inv;

  source_buffer #(
    .WL   (WL),
    .NUM  (NUM),
    .AW   (AW),
    .DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_a         (data_a),
    .write_address_a(write_address_a),
    .wren_a         (wren_a),
    .read_address_a (read_address_a),
    .q_a            (q_a),
    .data_b         (data_b),
    .write_address_b(write_address_b),
    .wren_b         (wren_b),
    .read_address_b (read_address_b),
    .q_b            (q_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge. Outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wren_a = 1'b0;
    wren_b = 1'b0;
    data_a = '0;
    data_b = '0;
    write_address_a = '0;
    write_address_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    read_address_a = '0;
    read_address_b = '0;
    step();
    step();
    $display("reset: q_a=%0h q_b=%0h", q_a[63:0], q_b[63:0]);
    assertions++;
    if (q_a !== '0) begin
      $display("FAIL reset_q_a: got %0h expected 0", q_a[63:0]);
      failures++;
    end
    assertions++;
    if (q_b !== '0) begin
      $display("FAIL reset_q_b: got %0h expected 0", q_b[63:0]);
      failures++;
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    wren_a = 1'b1; write_address_a = 10'd1; data_a = W'(111);
    wren_b = 1'b1; write_address_b = 10'd2; data_b = W'(123);
    step();
    $display("basic: write A[1]=111 B[2]=123");
    idle_inputs();
    read_address_a = 10'd1;
    read_address_b = 10'd2;
    step();
    $display("basic: read A[1]=%0d B[2]=%0d", q_a[31:0], q_b[31:0]);
    assertions++;
    if (q_a !== W'(111)) begin
      $display("FAIL basic_q_a: got %0h expected %0h", q_a[63:0], 111);
      failures++;
    end
    assertions++;
    if (q_b !== W'(123)) begin
      $display("FAIL basic_q_b: got %0h expected %0h", q_b[63:0], 123);
      failures++;
    end
    step();
    $display("basic: hold A=%0d B=%0d", q_a[31:0], q_b[31:0]);
    assertions++;
    if (q_a !== W'(111) || q_b !== W'(123)) begin
      $display("FAIL basic_hold: got a=%0h b=%0h expected a=%0h b=%0h",
               q_a[63:0], q_b[63:0], 111, 123);
      failures++;
    end
  endtask

  task automatic test_cross_port();
    wren_a = 1'b1; write_address_a = 10'd5; data_a = W'(16'hAAAA);
    step();
    $display("cross: write A[5]=aaaa");
    idle_inputs();
    read_address_a = 10'd5;
    read_address_b = 10'd5;
    step();
    $display("cross: read A[5]=%0h B[5]=%0h", q_a[63:0], q_b[63:0]);
    assertions++;
    if (q_a !== W'(16'hAAAA)) begin
      $display("FAIL cross_q_a: got %0h expected aaaa", q_a[63:0]);
      failures++;
    end
    assertions++;
    if (q_b !== W'(16'hAAAA)) begin
      $display("FAIL cross_q_b: got %0h expected aaaa", q_b[63:0]);
      failures++;
    end
  endtask

  task automatic test_read_during_write();
    wren_a = 1'b1; write_address_a = 10'd9; data_a = W'(7);
    step();
    $display("rdw: write A[9]=7");
    data_a = W'(8);
    read_address_a = 10'd9;
    read_address_b = 10'd9;
    step();
    $display("rdw: write A[9]=8 with read -> A=%0d B=%0d", q_a[31:0], q_b[31:0]);
    assertions++;
    if (q_a !== W'(7) || q_b !== W'(7)) begin
      $display("FAIL rdw_old: got a=%0h b=%0h expected 7", q_a[63:0], q_b[63:0]);
      failures++;
    end
    idle_inputs();
    step();
    $display("rdw: next read A=%0d B=%0d", q_a[31:0], q_b[31:0]);
    assertions++;
    if (q_a !== W'(8) || q_b !== W'(8)) begin
      $display("FAIL rdw_new: got a=%0h b=%0h expected 8", q_a[63:0], q_b[63:0]);
      failures++;
    end
    // The same old-data behaviour applies through write port B.
    wren_b = 1'b1; write_address_b = 10'd9; data_b = W'(9);
    step();
    $display("rdw: write B[9]=9 with read -> A=%0d B=%0d", q_a[31:0], q_b[31:0]);
    assertions++;
    if (q_a !== W'(8) || q_b !== W'(8)) begin
      $display("FAIL rdw_old_b: got a=%0h b=%0h expected 8", q_a[63:0], q_b[63:0]);
      failures++;
    end
    idle_inputs();
    step();
    assertions++;
    if (q_a !== W'(9) || q_b !== W'(9)) begin
      $display("FAIL rdw_new_b: got a=%0h b=%0h expected 9", q_a[63:0], q_b[63:0]);
      failures++;
    end
  endtask

  task automatic test_collision();
    wren_a = 1'b1; write_address_a = 10'd3; data_a = W'(8'h11);
    wren_b = 1'b1; write_address_b = 10'd3; data_b = W'(8'h22);
    step();
    $display("collision: A[3]=11 B[3]=22 same edge");
    idle_inputs();
    read_address_a = 10'd3;
    read_address_b = 10'd3;
    step();
    $display("collision: read A=%0h B=%0h", q_a[63:0], q_b[63:0]);
    assertions++;
    if (q_a !== W'(8'h11)) begin
      $display("FAIL collision_q_a: got %0h expected 11", q_a[63:0]);
      failures++;
    end
    assertions++;
    if (q_b !== W'(8'h11)) begin
      $display("FAIL collision_q_b: got %0h expected 11", q_b[63:0]);
      failures++;
    end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    read_address_a = 10'd1;
    read_address_b = 10'd2;
    step();
    $display("midreset: before A=%0d", q_a[31:0]);
    assertions++;
    if (q_a !== W'(111)) begin
      $display("FAIL midreset_pre: got %0h expected %0h", q_a[63:0], 111);
      failures++;
    end
    reset = 1'b1;
    wren_a = 1'b1; write_address_a = 10'd1; data_a = W'(55);
    step();
    $display("midreset: during reset A=%0h B=%0h", q_a[63:0], q_b[63:0]);
    assertions++;
    if (q_a !== '0 || q_b !== '0) begin
      $display("FAIL midreset_q: got a=%0h b=%0h expected 0", q_a[63:0], q_b[63:0]);
      failures++;
    end
    reset = 1'b0;
    idle_inputs();
    read_address_a = 10'd1;
    read_address_b = 10'd1;
    step();
    $display("midreset: after A[1]=%0d B[1]=%0d", q_a[31:0], q_b[31:0]);
    assertions++;
    if (q_a !== W'(111) || q_b !== W'(111)) begin
      $display("FAIL midreset_retain: got a=%0h b=%0h expected %0h",
               q_a[63:0], q_b[63:0], 111);
      failures++;
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NUM; i++) begin
      pattern[i*WL +: WL] = WL'(i);
    end
    pattern_inv = ~pattern;

    // The lane pattern goes to both ends of the address range.
    wren_a = 1'b1; write_address_a = 10'd0;    data_a = pattern;
    wren_b = 1'b1; write_address_b = 10'd1023; data_b = pattern;
    step();
    $display("boundary: write pattern to [0] and [1023]");
    idle_inputs();
    read_address_a = 10'd0;
    read_address_b = 10'd1023;
    step();
    assertions++;
    if (q_a !== pattern) begin
      $display("FAIL boundary_a0: got low %0h lane127 %0h expected low %0h lane127 %0h",
               q_a[63:0], q_a[W-1 -: WL], pattern[63:0], pattern[W-1 -: WL]);
      failures++;
    end
    assertions++;
    if (q_b !== pattern) begin
      $display("FAIL boundary_b1023: got low %0h lane127 %0h expected low %0h lane127 %0h",
               q_b[63:0], q_b[W-1 -: WL], pattern[63:0], pattern[W-1 -: WL]);
      failures++;
    end
    read_address_a = 10'd1023;
    read_address_b = 10'd0;
    step();
    $display("boundary: swapped read ports");
    assertions++;
    if (q_a !== pattern || q_b !== pattern) begin
      $display("FAIL boundary_swap: got a_low %0h b_low %0h expected %0h",
               q_a[63:0], q_b[63:0], pattern[63:0]);
      failures++;
    end

    // Overwrite the top entry with the inverse. Entry 0 must be unaffected.
    wren_b = 1'b1; write_address_b = 10'd1023; data_b = pattern_inv;
    step();
    idle_inputs();
    read_address_a = 10'd0;
    read_address_b = 10'd1023;
    step();
    $display("boundary: alias check A[0] low %0h B[1023] low %0h", q_a[63:0], q_b[63:0]);
    assertions++;
    if (q_a !== pattern) begin
      $display("FAIL boundary_alias0: got low %0h expected low %0h", q_a[63:0], pattern[63:0]);
      failures++;
    end
    assertions++;
    if (q_b !== pattern_inv) begin
      $display("FAIL boundary_alias1023: got low %0h expected low %0h",
               q_b[63:0], pattern_inv[63:0]);
      failures++;
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    reset = 1'b1;
    read_address_a = '0;
    read_address_b = '0;
    idle_inputs();

    test_reset();
    test_basic();
    test_cross_port();
    test_read_during_write();
    test_collision();
    test_reset_midstream();
    test_boundary();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
